// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single eviction-write-buffer port between the I-cache and D-cache.
// Round-robin on ties, one registered transaction in flight until ewb_resp_i.
module cache_mem_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read_i,
    input  logic [ADDR_W-1:0] i_address_i,
    output logic [LINE_W-1:0] i_rdata_o,
    output logic              i_resp_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [LINE_W-1:0] d_wdata_i,
    input  logic [ADDR_W-1:0] d_address_i,
    output logic [LINE_W-1:0] d_rdata_o,
    output logic              d_resp_o,
    output logic              ewb_read_o,
    output logic              ewb_write_o,
    output logic [LINE_W-1:0] ewb_wdata_o,
    output logic [ADDR_W-1:0] ewb_address_o,
    input  logic [LINE_W-1:0] ewb_rdata_i,
    input  logic              ewb_resp_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    logic   last_d;
    logic   d_req;
    logic   grant_d;

    assign d_req   = d_read_i | d_write_i;
    // D wins when alone, or on a tie when the previous grant went to I.
    assign grant_d = d_req & (~i_read_i | ~last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_d        <= 1'b0;
            ewb_read_o    <= 1'b0;
            ewb_write_o   <= 1'b0;
            ewb_address_o <= '0;
            ewb_wdata_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_read_i | d_req) begin
                        last_d        <= grant_d;
                        state         <= grant_d ? SERVE_D : SERVE_I;
                        ewb_address_o <= grant_d ? d_address_i : i_address_i;
                        // A simultaneous D read+write is treated as a write.
                        ewb_write_o   <= grant_d & d_write_i;
                        ewb_read_o    <= grant_d ? ~d_write_i : 1'b1;
                        ewb_wdata_o   <= (grant_d & d_write_i) ? d_wdata_i : '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (ewb_resp_i) begin
                        state         <= IDLE;
                        ewb_read_o    <= 1'b0;
                        ewb_write_o   <= 1'b0;
                        ewb_address_o <= '0;
                        ewb_wdata_o   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is returned in the same cycle as the ewb response.
    assign i_resp_o  = (state == SERVE_I) & ewb_resp_i;
    assign d_resp_o  = (state == SERVE_D) & ewb_resp_i;
    assign i_rdata_o = ewb_rdata_i;
    assign d_rdata_o = ewb_rdata_i;

endmodule
